// File: rtl/jpeg_rle_pkg.sv
// Shared types and constants for the JPEG run-length/amplitude encoder.
// Symbol layout on the output bus (LSB first):
//   [3:0] size, [7:4] run, [8 +: AMP_WIDTH] amplitude,
//   [8+AMP_WIDTH] is_dc, [9+AMP_WIDTH] eob, remaining bits zero.
package jpeg_rle_pkg;

   localparam int BLOCK_SIZE = 64;
   localparam int IDX_W      = $clog2(BLOCK_SIZE);
   localparam int LAST_IDX   = BLOCK_SIZE - 1;

   localparam int SIZE_LSB = 0;
   localparam int RUN_LSB  = 4;
   localparam int AMP_LSB  = 8;

   localparam logic [3:0] ZRL_RUN      = 4'd15;
   localparam logic [1:0] ZRL_PEND_MAX = 2'd3;

   // Control half of a symbol; the amplitude is carried separately because
   // its width is a module parameter.
   typedef struct packed {
      logic       eob;
      logic       is_dc;
      logic [3:0] run;
      logic [3:0] size;
   } sym_ctl_t;

   localparam sym_ctl_t ZRL_CTL = '{eob: 1'b0, is_dc: 1'b0, run: ZRL_RUN, size: 4'd0};
   localparam sym_ctl_t EOB_CTL = '{eob: 1'b1, is_dc: 1'b0, run: 4'd0,    size: 4'd0};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_ZRL_DRAIN
   } state_e;

   // JPEG size category: bit length of a magnitude (0 for 0).
   function automatic logic [3:0] size_cat(input logic [14:0] mag);
      logic [3:0] s;
      s = 4'd0;
      for (int i = 0; i < 15; i++) begin
         if (mag[i]) s = 4'(i + 1);
      end
      return s;
   endfunction

endpackage

// File: rtl/jpeg_rle_enc_amp.sv
// Combinational size-category and amplitude encoder.
// Negative values use the JPEG one's-complement form: (v-1) masked to size bits.
module jpeg_amp_enc
   import jpeg_rle_pkg::*;
#(
   parameter int AMP_WIDTH = 13
) (
   input  logic signed [AMP_WIDTH-1:0] val_i,
   output logic        [3:0]           size_o,
   output logic        [AMP_WIDTH-1:0] amp_o
);

   logic [AMP_WIDTH-1:0] mag;
   logic [AMP_WIDTH-1:0] mask;

   // Magnitude, size category and masked amplitude of the input value.
   always_comb begin
      mag    = val_i[AMP_WIDTH-1] ? AMP_WIDTH'(-val_i) : AMP_WIDTH'(val_i);
      size_o = size_cat(15'(mag));
      mask   = (AMP_WIDTH'(1) << size_o) - AMP_WIDTH'(1);
      amp_o  = val_i[AMP_WIDTH-1] ? ((AMP_WIDTH'(val_i) - AMP_WIDTH'(1)) & mask)
                                  : AMP_WIDTH'(val_i);
   end

endmodule

// File: rtl/jpeg_rle_enc.sv
// JPEG run-length / amplitude encoder, one quantized coefficient per beat,
// 64 beats per 8x8 block in zig-zag order. Emits DC, AC, ZRL and EOB symbols
// through a single output register.
// Optional build macro JPEG_RLE_DC_DIFF_EN: DC is coded as a DPCM difference
// against the previous block's DC (predictor cleared by tuser and reset).
module jpeg_rle_enc
   import jpeg_rle_pkg::*;
#(
   parameter int COEF_WIDTH      = 12,
   parameter int AMP_WIDTH       = COEF_WIDTH + 1,
   parameter int IN_TDATA_WIDTH  = ((COEF_WIDTH + 7) / 8) * 8,
   parameter int OUT_TDATA_WIDTH = ((10 + AMP_WIDTH + 7) / 8) * 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         coef_tvalid_i,
   output logic                         coef_tready_o,
   input  logic [IN_TDATA_WIDTH-1:0]    coef_tdata_i,
   input  logic                         coef_tuser_i,
   input  logic                         coef_tlast_i,
   output logic                         sym_tvalid_o,
   input  logic                         sym_tready_i,
   output logic [OUT_TDATA_WIDTH-1:0]   sym_tdata_o,
   output logic [OUT_TDATA_WIDTH/8-1:0] sym_tstrb_o,
   output logic [OUT_TDATA_WIDTH/8-1:0] sym_tkeep_o,
   output logic                         sym_tlast_o,
   output logic                         sym_tuser_o
);

   function automatic logic [OUT_TDATA_WIDTH-1:0] pack_sym(input sym_ctl_t ctl,
                                                          input logic [AMP_WIDTH-1:0] amp);
      logic [OUT_TDATA_WIDTH-1:0] d;
      d = '0;
      d[SIZE_LSB +: 4]         = ctl.size;
      d[RUN_LSB +: 4]          = ctl.run;
      d[AMP_LSB +: AMP_WIDTH]  = amp;
      d[AMP_LSB + AMP_WIDTH]   = ctl.is_dc;
      d[AMP_LSB + AMP_WIDTH + 1] = ctl.eob;
      return d;
   endfunction

   state_e                       state_q, state_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [3:0]                   zero_run_q, zero_run_d;
   logic [1:0]                   zrl_pend_q, zrl_pend_d;
   logic                         sym_valid_q, sym_valid_d;
   logic [OUT_TDATA_WIDTH-1:0]   sym_data_q, sym_data_d;
   logic                         sym_last_q, sym_last_d;
   logic                         sym_user_q, sym_user_d;
   logic [OUT_TDATA_WIDTH-1:0]   hold_data_q, hold_data_d;
   logic                         hold_last_q, hold_last_d;

   logic signed [AMP_WIDTH-1:0]  coef_ext;
   logic signed [AMP_WIDTH-1:0]  dc_val;
   logic signed [AMP_WIDTH-1:0]  enc_val;
   logic [3:0]                   enc_size;
   logic [AMP_WIDTH-1:0]         enc_amp;
   logic                         coef_acc, sym_pop, is_dc, is_last_idx, coef_zero;
   sym_ctl_t                     cur_ctl;
   logic [OUT_TDATA_WIDTH-1:0]   cur_sym;
   logic                         unused_tdata;

   // Upper tdata padding bits carry no information.
   assign unused_tdata = ^coef_tdata_i;

   assign coef_ext    = AMP_WIDTH'($signed(coef_tdata_i[COEF_WIDTH-1:0]));
   assign coef_zero   = (coef_tdata_i[COEF_WIDTH-1:0] == '0);
   assign is_dc       = (idx_q == '0);
   assign is_last_idx = (idx_q == IDX_W'(LAST_IDX));

`ifdef JPEG_RLE_DC_DIFF_EN
   logic signed [AMP_WIDTH-1:0] pred_q, pred_d;
   // A tuser DC beat restarts prediction, so the difference is the DC itself.
   assign dc_val = coef_tuser_i ? coef_ext : (coef_ext - pred_q);
`else
   assign dc_val = coef_ext;
`endif

   assign enc_val = is_dc ? dc_val : coef_ext;

   jpeg_amp_enc #(.AMP_WIDTH(AMP_WIDTH)) u_amp_enc (
      .val_i  (enc_val),
      .size_o (enc_size),
      .amp_o  (enc_amp)
   );

   assign cur_ctl = '{eob: 1'b0, is_dc: is_dc, run: (is_dc ? 4'd0 : zero_run_q), size: enc_size};
   assign cur_sym = pack_sym(cur_ctl, enc_amp);

   assign coef_tready_o = (!sym_valid_q || sym_tready_i) && (state_q != ST_ZRL_DRAIN);
   assign coef_acc      = coef_tvalid_i && coef_tready_o;
   assign sym_pop       = sym_valid_q && sym_tready_i;

   assign sym_tvalid_o = sym_valid_q;
   assign sym_tdata_o  = sym_data_q;
   assign sym_tlast_o  = sym_last_q;
   assign sym_tuser_o  = sym_user_q;
   assign sym_tstrb_o  = '1;
   assign sym_tkeep_o  = '1;

   // Next-state logic: framing counters, run tracking, ZRL drain and output load.
   always_comb begin
      // NOTE: every _d starts from its held value so no branch can infer a latch.
      state_d     = state_q;
      idx_d       = idx_q;
      zero_run_d  = zero_run_q;
      zrl_pend_d  = zrl_pend_q;
      sym_valid_d = sym_valid_q;
      sym_data_d  = sym_data_q;
      sym_last_d  = sym_last_q;
      sym_user_d  = sym_user_q;
      hold_data_d = hold_data_q;
      hold_last_d = hold_last_q;
`ifdef JPEG_RLE_DC_DIFF_EN
      pred_d      = pred_q;
`endif

      if (sym_pop) sym_valid_d = 1'b0;

      if (state_q == ST_ZRL_DRAIN) begin
         if (sym_pop) begin
            sym_valid_d = 1'b1;
            sym_user_d  = 1'b0;
            if (zrl_pend_q != 2'd0) begin
               sym_data_d = pack_sym(ZRL_CTL, '0);
               sym_last_d = 1'b0;
               zrl_pend_d = zrl_pend_q - 2'd1;
            end else begin
               sym_data_d = hold_data_q;
               sym_last_d = hold_last_q;
               state_d    = is_dc ? ST_IDLE : ST_RUN;
            end
         end
      end else if (coef_acc) begin
         idx_d   = idx_q + IDX_W'(1);
         state_d = is_last_idx ? ST_IDLE : ST_RUN;
         if (is_dc) begin
            sym_valid_d = 1'b1;
            sym_data_d  = cur_sym;
            sym_last_d  = 1'b0;
            sym_user_d  = coef_tuser_i;
            zero_run_d  = 4'd0;
            zrl_pend_d  = 2'd0;
`ifdef JPEG_RLE_DC_DIFF_EN
            pred_d      = coef_ext;
`endif
         end else if (coef_zero) begin
            if (is_last_idx) begin
               // Trailing zeros collapse into EOB; pending ZRLs are dropped.
               sym_valid_d = 1'b1;
               sym_data_d  = pack_sym(EOB_CTL, '0);
               sym_last_d  = coef_tlast_i;
               sym_user_d  = 1'b0;
               zero_run_d  = 4'd0;
               zrl_pend_d  = 2'd0;
            end else if (zero_run_q == ZRL_RUN) begin
               zero_run_d = 4'd0;
               if (zrl_pend_q != ZRL_PEND_MAX) zrl_pend_d = zrl_pend_q + 2'd1;
            end else begin
               zero_run_d = zero_run_q + 4'd1;
            end
         end else begin
            zero_run_d  = 4'd0;
            sym_valid_d = 1'b1;
            sym_user_d  = 1'b0;
            if (zrl_pend_q != 2'd0) begin
               // First ZRL goes out now; the coded coefficient waits in hold.
               sym_data_d  = pack_sym(ZRL_CTL, '0);
               sym_last_d  = 1'b0;
               zrl_pend_d  = zrl_pend_q - 2'd1;
               hold_data_d = cur_sym;
               hold_last_d = is_last_idx && coef_tlast_i;
               state_d     = ST_ZRL_DRAIN;
            end else begin
               sym_data_d  = cur_sym;
               sym_last_d  = is_last_idx && coef_tlast_i;
               zrl_pend_d  = 2'd0;
            end
         end
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         zero_run_q  <= '0;
         zrl_pend_q  <= '0;
         sym_valid_q <= 1'b0;
         sym_data_q  <= '0;
         sym_last_q  <= 1'b0;
         sym_user_q  <= 1'b0;
         hold_data_q <= '0;
         hold_last_q <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values.
         state_q     <= state_d;
         idx_q       <= idx_d;
         zero_run_q  <= zero_run_d;
         zrl_pend_q  <= zrl_pend_d;
         sym_valid_q <= sym_valid_d;
         sym_data_q  <= sym_data_d;
         sym_last_q  <= sym_last_d;
         sym_user_q  <= sym_user_d;
         hold_data_q <= hold_data_d;
         hold_last_q <= hold_last_d;
      end
   end

`ifdef JPEG_RLE_DC_DIFF_EN
   // DC predictor register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) pred_q <= '0;
      else       pred_q <= pred_d;
   end
`endif

endmodule
